tag_array_ctrl: RTL and testbench

Initiator-side controller for the 128×24 single-read/single-write tag RAM used by the L1 caches. It drives the RAM's read and write ports. After reset or a flush request it sweeps all 128 entries to zero. It arbitrates client lookups against tag updates and returns lookup data with a fixed one-cycle latency. It sits between the cache FSM (the client) and the RAM instance, and owns every RAM port.

---
 rtl/tag_array_ctrl.sv | 153 +++++++++++++++
 tb/tb_tag_array_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl: initiator-side controller for the L1 tag RAM (one read port, one write port).
// After reset or flush it zeroes every entry. Outside a sweep it passes tag updates
// straight to the write port and answers client lookups exactly one cycle after acceptance.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// The client may hold valid high while ready is low. Ready never depends on the same
// port's valid. Update data is written in the same cycle it is accepted.
//
// Optional feature macro: TAG_BYPASS_EN.
//   Defined:   a lookup that collides with a same-cycle update to the same index is
//              still accepted, and its response comes from a registered copy of the update.
//   Undefined: a colliding lookup is held off for one cycle, then reads the new value from the RAM.
// Either way, a RAM read-during-write result never reaches the client.
module tag_array_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rd,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wr,
    output logic              ram_we
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;        // one spare bit so the sweep index cannot wrap
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_hold_q;  // last delivered response, shown while idle
    logic [DATA_W-1:0] resp_now;     // response value for the current response cycle
    logic              in_sweep;
    logic              in_run;
    logic              same_addr;
    logic              fire;

    // All port-facing enables are forced low while rst is high.
    assign in_sweep  = (state_q == ST_SWEEP) && !rst;
    assign in_run    = (state_q == ST_RUN) && !rst;
    assign same_addr = upd_valid && (upd_addr == req_addr);

`ifdef TAG_BYPASS_EN
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q;

    assign req_ready = in_run;
    assign resp_now  = byp_q ? byp_data_q : ram_rd;

    // Remember a same-index update that collided with an accepted lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q <= fire && same_addr;
            if (fire && same_addr) begin
                byp_data_q <= upd_data;
            end
        end
    end
`else
    assign req_ready = in_run && !same_addr;
    assign resp_now  = ram_rd;
`endif

    assign fire      = req_valid && req_ready;
    assign upd_ready = in_run;
    assign busy      = (state_q == ST_SWEEP) || rst;

    // The RAM ports are driven by the sweep or, outside a sweep, by the client and updater.
    always_comb begin
        ram_re    = fire;
        ram_raddr = req_addr;
        ram_we    = 1'b0;
        ram_waddr = upd_addr;
        ram_wr    = upd_data;
        if (in_sweep) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q[ADDR_W-1:0];
            ram_wr    = '0;
        end else if (in_run) begin
            ram_we = upd_valid;
        end
    end

    // Sweep/run state machine. A flush in either state restarts the sweep at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_SWEEP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The response pulse follows acceptance by one cycle. The value is held until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_hold_q  <= '0;
        end else begin
            resp_valid_q <= fire;
            if (resp_valid_q) begin
                resp_hold_q <= resp_now;
            end
        end
    end

    assign resp_valid = resp_valid_q && !rst;
    assign resp_data  = resp_valid_q ? resp_now : resp_hold_q;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Testbench for tag_array_ctrl. It includes a behavioural tag RAM. A reference model
// tracks the expected tag contents, the remaining sweep length, and the queue of
// expected lookup responses.
module tb_tag_array_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 24;
    localparam int DEPTH = 1 << AW;
`ifdef TAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [DW-1:0] upd_data;
    logic          flush;
    logic          busy;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_rd;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wr;
    logic          ram_we;

    tag_array_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
        .flush(flush), .busy(busy),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rd(ram_rd),
        .ram_waddr(ram_waddr), .ram_wr(ram_wr), .ram_we(ram_we)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural tag RAM. A read of the index being written returns X, so a leak is visible.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_re) begin
            if (ram_we && (ram_waddr == ram_raddr)) ram_rd <= 'x;
            else ram_rd <= ram_mem[ram_raddr];
        end
        if (ram_we) ram_mem[ram_waddr] <= ram_wr;
    end

    // Reference model and scoreboard
    int            checks;
    int            errors;
    logic [DW-1:0] ref_mem [DEPTH];
    int            sweep_left;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_resp;

    // Values seen mid-cycle by the most recent drive_cycle call
    logic          obs_busy;
    logic          obs_req_ready;
    logic          obs_resp_valid;
    logic [DW-1:0] obs_resp_data;
    logic          obs_ram_we;

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Driver: apply one cycle of inputs, compare outputs mid-cycle, then advance the model on the edge.
    task automatic drive_cycle(input bit r, input bit rv, input logic [AW-1:0] ra,
                               input bit uv, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                               input bit fl);
        bit            in_sweep;
        bit            collide;
        bit            exp_rr;
        bit            acc;
        logic [DW-1:0] e;
        rst = r; req_valid = rv; req_addr = ra;
        upd_valid = uv; upd_addr = ua; upd_data = ud; flush = fl;
        #4;
        obs_busy = busy; obs_req_ready = req_ready; obs_resp_valid = resp_valid;
        obs_resp_data = resp_data; obs_ram_we = ram_we;
        in_sweep = (sweep_left > 0);
        collide  = uv && (ua == ra);
        exp_rr   = !in_sweep && (BYPASS || !collide);
        acc      = rv && exp_rr;
        if (r) begin
            checks += 3;
            if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
            if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_ram_re got %b exp 0", ram_re); end
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        end else begin
            checks += 3;
            if (busy !== in_sweep) begin errors++; $display("FAIL busy got %b exp %b", busy, in_sweep); end
            if (req_ready !== exp_rr) begin errors++; $display("FAIL req_ready got %b exp %b", req_ready, exp_rr); end
            if (upd_ready !== !in_sweep) begin errors++; $display("FAIL upd_ready got %b exp %b", upd_ready, !in_sweep); end
            if (in_sweep) begin
                checks += 4;
                if (ram_we !== 1'b1) begin errors++; $display("FAIL sweep_we got %b exp 1", ram_we); end
                if (ram_waddr !== AW'(DEPTH - sweep_left)) begin
                    errors++; $display("FAIL sweep_waddr got %0d exp %0d", ram_waddr, DEPTH - sweep_left);
                end
                if (ram_wr !== '0) begin errors++; $display("FAIL sweep_wr got %h exp 0", ram_wr); end
                if (ram_re !== 1'b0) begin errors++; $display("FAIL sweep_re got %b exp 0", ram_re); end
            end else begin
                checks += 2;
                if (ram_we !== uv) begin errors++; $display("FAIL run_we got %b exp %b", ram_we, uv); end
                if (ram_re !== acc) begin errors++; $display("FAIL run_re got %b exp %b", ram_re, acc); end
                if (uv) begin
                    checks++;
                    if (ram_waddr !== ua || ram_wr !== ud) begin
                        errors++; $display("FAIL run_write got %0d/%h exp %0d/%h", ram_waddr, ram_wr, ua, ud);
                    end
                end
                if (acc) begin
                    checks++;
                    if (ram_raddr !== ra) begin errors++; $display("FAIL run_raddr got %0d exp %0d", ram_raddr, ra); end
                end
            end
            checks += 2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_resp = e;
                if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_valid got %b exp 1", resp_valid); end
                if (resp_data !== e) begin errors++; $display("FAIL resp_data got %h exp %h", resp_data, e); end
            end else begin
                if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_valid got %b exp 0", resp_valid); end
                if (resp_data !== last_resp) begin errors++; $display("FAIL resp_hold got %h exp %h", resp_data, last_resp); end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            sweep_left = DEPTH;
            exp_q.delete();
            last_resp = '0;
            clear_ref();
        end else begin
            if (acc) exp_q.push_back((BYPASS && collide) ? ud : ref_mem[ra]);
            if (uv && !in_sweep) ref_mem[ua] = ud;
            if (fl) begin
                sweep_left = DEPTH;
                clear_ref();
            end else if (in_sweep) begin
                sweep_left--;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 0, '0, '0, 0);
    endtask

    task automatic test_reset();
        int busy_cnt;
        drive_cycle(1, 0, '0, 0, '0, '0, 0);
        drive_cycle(1, 0, '0, 0, '0, '0, 0);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(0, 0, '0, 0, '0, '0, 0);
            if (obs_busy === 1'b1 && obs_req_ready === 1'b0 && obs_ram_we === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != DEPTH) begin errors++; $display("FAIL reset_sweep_len got %0d exp %0d", busy_cnt, DEPTH); end
        drive_cycle(0, 1, 7'd0, 0, '0, '0, 0);
        checks++;
        if (obs_busy !== 1'b0 || obs_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cycle129 got busy=%b ready=%b exp busy=0 ready=1", obs_busy, obs_req_ready);
        end
        idle(1);
        checks++;
        if (obs_resp_valid !== 1'b1 || obs_resp_data !== 24'h0) begin
            errors++; $display("FAIL reset_zeroed got %b/%h exp 1/000000", obs_resp_valid, obs_resp_data);
        end
    endtask

    task automatic test_basic_lookup();
        drive_cycle(0, 0, '0, 1, 7'd5, 24'hABCDEF, 0);
        drive_cycle(0, 1, 7'd5, 0, '0, '0, 0);
        idle(1);
        checks++;
        if (obs_resp_valid !== 1'b1 || obs_resp_data !== 24'hABCDEF) begin
            errors++; $display("FAIL basic_lookup got %b/%h exp 1/abcdef", obs_resp_valid, obs_resp_data);
        end
    endtask

    task automatic test_collision();
        drive_cycle(0, 1, 7'd9, 1, 7'd9, 24'h123456, 0);
        checks++;
        if (obs_req_ready !== BYPASS) begin
            errors++; $display("FAIL collide_ready got %b exp %b", obs_req_ready, BYPASS);
        end
        if (!BYPASS) begin
            drive_cycle(0, 1, 7'd9, 0, '0, '0, 0);
            checks++;
            if (obs_req_ready !== 1'b1) begin errors++; $display("FAIL collide_retry_ready got %b exp 1", obs_req_ready); end
        end
        idle(1);
        checks++;
        if (obs_resp_valid !== 1'b1 || obs_resp_data !== 24'h123456) begin
            errors++; $display("FAIL collide_resp got %b/%h exp 1/123456", obs_resp_valid, obs_resp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = DW'($urandom);
            drive_cycle(0, 0, '0, 1, AW'(20 + i), vals[i], 0);
        end
        for (int i = 0; i < 9; i++) begin
            drive_cycle(0, (i < 8), AW'(20 + i), 0, '0, '0, 0);
            if (i > 0) begin
                checks++;
                if (obs_resp_valid !== 1'b1 || obs_resp_data !== vals[i-1]) begin
                    errors++; $display("FAIL b2b_resp%0d got %b/%h exp 1/%h", i - 1, obs_resp_valid, obs_resp_data, vals[i-1]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int busy_cnt;
        drive_cycle(0, 0, '0, 1, 7'd3, 24'h5A5A5A, 0);
        drive_cycle(0, 1, 7'd3, 0, '0, '0, 1);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(0, 0, '0, 0, '0, '0, 0);
            if (i == 0) begin
                checks++;
                if (obs_resp_valid !== 1'b1 || obs_resp_data !== 24'h5A5A5A) begin
                    errors++; $display("FAIL flush_resp got %b/%h exp 1/5a5a5a", obs_resp_valid, obs_resp_data);
                end
            end
            if (obs_busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != DEPTH) begin errors++; $display("FAIL flush_busy_len got %0d exp %0d", busy_cnt, DEPTH); end
        drive_cycle(0, 1, 7'd3, 0, '0, '0, 0);
        idle(1);
        checks++;
        if (obs_resp_valid !== 1'b1 || obs_resp_data !== 24'h0) begin
            errors++; $display("FAIL flush_cleared got %b/%h exp 1/000000", obs_resp_valid, obs_resp_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        drive_cycle(0, 0, '0, 0, '0, '0, 1);
        idle(60);
        drive_cycle(1, 0, '0, 0, '0, '0, 0);
        checks++;
        if (obs_ram_we !== 1'b0) begin errors++; $display("FAIL midsweep_rst_we got %b exp 0", obs_ram_we); end
        drive_cycle(1, 0, '0, 0, '0, '0, 0);
        idle(DEPTH);
        // Lookup accepted, then reset on the next cycle: its response must be dropped.
        drive_cycle(0, 1, 7'd11, 0, '0, '0, 0);
        drive_cycle(1, 0, '0, 0, '0, '0, 0);
        checks++;
        if (obs_resp_valid !== 1'b0) begin errors++; $display("FAIL midlookup_rst got %b exp 0", obs_resp_valid); end
        idle(1);
        checks++;
        if (obs_resp_valid !== 1'b0 || obs_resp_data !== 24'h0) begin
            errors++; $display("FAIL midlookup_after got %b/%h exp 0/000000", obs_resp_valid, obs_resp_data);
        end
        idle(DEPTH - 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(0, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                        bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                        ($urandom_range(0, 149) == 0));
        end
        idle(DEPTH + 2);
    endtask

    initial begin
        checks = 0; errors = 0;
        sweep_left = DEPTH; last_resp = '0;
        clear_ref();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0;
        upd_valid = 1'b0; upd_addr = '0; upd_data = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_lookup();
        test_collision();
        test_back_to_back();
        test_flush();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
